// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/sub, SLICE bits per stage, global stall; PIPE_ADDER_SAT_EN clamps on signed overflow
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int NSTAGE = WIDTH / SLICE;
  localparam int L = NSTAGE - 1;
  logic stall;
  logic [WIDTH-1:0] xa [NSTAGE];
  logic [WIDTH-1:0] xb [NSTAGE];
  logic [WIDTH-1:0] xs [NSTAGE];
  logic xc [NSTAGE];
  logic xv [NSTAGE];
  logic [SLICE:0] t;
  logic [WIDTH-1:0] fs;
  logic ov;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  assign xa[0] = a;
  assign xb[0] = sub ? ~b : b;
  assign xs[0] = '0;
  assign xc[0] = sub | c_in;
  assign xv[0] = in_valid;
  for (genvar k = 0; k < L; k++) begin : g_st
    logic [SLICE:0] p;
    logic [WIDTH-1:0] ra, rb, rs;
    logic rc, rv;
    assign p = {1'b0, xa[k][k*SLICE +: SLICE]} + {1'b0, xb[k][k*SLICE +: SLICE]} + {{SLICE{1'b0}}, xc[k]};
    always_ff @(posedge clk)
      if (rst) rv <= 1'b0;
      else if (!stall) begin
        rv <= xv[k];
        ra <= xa[k];
        rb <= xb[k];
        rc <= p[SLICE];
        rs <= xs[k] | (WIDTH'(p[SLICE-1:0]) << (k*SLICE));
      end
    assign xa[k+1] = ra;
    assign xb[k+1] = rb;
    assign xs[k+1] = rs;
    assign xc[k+1] = rc;
    assign xv[k+1] = rv;
  end
  assign t = {1'b0, xa[L][L*SLICE +: SLICE]} + {1'b0, xb[L][L*SLICE +: SLICE]} + {{SLICE{1'b0}}, xc[L]};
  assign ov = xa[L][WIDTH-1] ^ xb[L][WIDTH-1] ^ t[SLICE-1] ^ t[SLICE];
`ifdef PIPE_ADDER_SAT_EN
  assign fs = ov ? {xa[L][WIDTH-1], {(WIDTH-1){~xa[L][WIDTH-1]}}} : xs[L] | (WIDTH'(t[SLICE-1:0]) << (L*SLICE));
`else
  assign fs = xs[L] | (WIDTH'(t[SLICE-1:0]) << (L*SLICE));
`endif
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      sum <= '0;
      c_out <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (!stall) begin
      out_valid <= xv[L];
      sum <= fs;
      c_out <= t[SLICE];
      ovf <= ov;
      zero <= fs == '0;
    end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized and directed checks of pipe_adder against an arithmetic reference model
module tb_pipe_adder;
  localparam int W = 32;
  logic clk = 0, rst = 1, in_valid = 0, sub = 0, c_in = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready [3];
  logic out_valid [3];
  logic c_out [3];
  logic ovf [3];
  logic zero [3];
  logic [W-1:0] sum [3];
  int n = 0, errs = 0;
  logic [W+2:0] q [$];
  logic pat_en = 0;
  logic [5:0] pat = 6'b010011;
  int cyc = 0;

  pipe_adder #(.WIDTH(W), .SLICE(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid[0]), .out_ready(out_ready),
    .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0]), .zero(zero[0]));
  pipe_adder #(.WIDTH(W), .SLICE(32)) u32 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid[1]), .out_ready(out_ready),
    .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1]), .zero(zero[1]));
  pipe_adder #(.WIDTH(W), .SLICE(4)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid[2]), .out_ready(out_ready),
    .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2]), .zero(zero[2]));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [W+2:0] model(logic [W-1:0] x, logic [W-1:0] y, logic s, logic ci);
    logic [W:0] r;
    logic [W-1:0] yb;
    logic o;
    yb = s ? ~y : y;
    r = {1'b0, x} + {1'b0, yb} + (W+1)'(s | ci);
    o = (x[W-1] == yb[W-1]) && (r[W-1] != x[W-1]);
`ifdef PIPE_ADDER_SAT_EN
    if (o) r[W-1:0] = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {r[W-1:0], r[W], o, r[W-1:0] == '0};
  endfunction

  always @(posedge clk) begin
    #1;
    if (pat_en) begin
      out_ready = pat[cyc % 6];
      cyc++;
    end
  end

  logic was_stall = 0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (rst) begin
      q.delete();
      was_stall = 0;
    end else begin
      if (was_stall) check("stall_hold", 64'(sum[0]), 64'(held));
      check("in_ready", 64'(in_ready[0]), 64'(!(out_valid[0] && !out_ready)));
      if (out_valid[0] && out_ready) begin
        check("no_extra_beat", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("beat", 64'({sum[0], c_out[0], ovf[0], zero[0]}), 64'(e));
        end
      end
      if (in_valid && in_ready[0]) q.push_back(model(a, b, sub, c_in));
      was_stall = out_valid[0] && !out_ready;
      held = sum[0];
    end
  end

  task automatic beat(logic [W-1:0] x, logic [W-1:0] y, logic s, logic ci);
    logic acc;
    int g = 0;
    a = x;
    b = y;
    sub = s;
    c_in = ci;
    in_valid = 1;
    do begin
      @(negedge clk);
      acc = in_ready[0];
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 50);
    check("accept", 64'(acc), 64'(1));
  endtask

  task automatic dir(string tag, logic [W-1:0] x, logic [W-1:0] y, logic s, logic ci,
                     logic [W-1:0] es, logic ec, logic eo, logic ez);
    int g = 0;
    beat(x, y, s, ci);
    in_valid = 0;
    while (!out_valid[0] && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check({tag, "_valid"}, 64'(out_valid[0]), 64'(1));
    check({tag, "_sum"}, 64'(sum[0]), 64'(es));
    check({tag, "_cout"}, 64'(c_out[0]), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf[0]), 64'(eo));
    check({tag, "_zero"}, 64'(zero[0]), 64'(ez));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    rst = 1;
    in_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", 64'(out_valid[i]), 64'(0));
      check("rst_sum", 64'(sum[i]), 64'(0));
      check("rst_flags", 64'({c_out[i], ovf[i], zero[i]}), 64'(0));
      check("rst_ready", 64'(in_ready[i]), 64'(1));
    end
  endtask

  task automatic lat(int i, int want);
    int g = 1;
    reset_check();
    a = 60000000;
    b = 3789621;
    sub = 0;
    c_in = 0;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    while (!out_valid[i] && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("latency", 64'(g), 64'(want));
    check("lat_sum", 64'(sum[i]), 64'(63789621));
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    dir("add", 60000000, 3789621, 0, 0, 63789621, 0, 0, 0);
    dir("sub_neg", 5, 7, 1, 0, 32'hFFFFFFFE, 0, 0, 0);
    dir("sub_pos", 7, 5, 1, 1, 2, 1, 0, 0);
`ifdef PIPE_ADDER_SAT_EN
    dir("ovf", 32'h7FFFFFFF, 1, 0, 0, 32'h7FFFFFFF, 0, 1, 0);
`else
    dir("ovf", 32'h7FFFFFFF, 1, 0, 0, 32'h80000000, 0, 1, 0);
`endif
    dir("carry_all", 32'hFFFFFFFF, 0, 0, 1, 0, 1, 0, 1);
    pat_en = 1;
    for (int i = 0; i < 20; i++) beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 0;
    repeat (20) @(posedge clk);
    pat_en = 0;
    #2;
    out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    check("drain", 64'(q.size()), 64'(0));
    for (int i = 0; i < 3; i++) beat($urandom, $urandom, 1'(i), 0);
    in_valid = 0;
    reset_check();
    repeat (12) @(posedge clk);
    #1;
    check("no_stale", 64'(q.size()), 64'(0));
    lat(0, 4);
    lat(1, 1);
    lat(2, 8);
    check("final_drain", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end
endmodule
